scope_capture_engine: RTL and testbench
=======================================

Name: scope_capture_engine

Overview:
- Parametrised multi-channel oscilloscope capture engine.
- Decimates ADC samples in sample, max-hold or min-hold mode and stores them in an internal circular buffer with a programmable pre-trigger length.
- Detects edge triggers with hysteresis. Supports auto, normal and single modes, force trigger and holdoff.
- Sits between the ADC front end and the display/readout logic; capture completion uses a done/ack handshake.

Parameters:
- CH_NUM, 2, number of ADC channels captured in lockstep.
- DW, 8, sample width in bits.
- DEPTH, 16384, samples per channel; must be a power of two.
- AW, log2(DEPTH), buffer address width (derived).
- TW, 32, width of the decimation, timeout and holdoff counters.

Ports:
- clk  in  1  system/sample clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- ad_data  in  CH_NUM*DW  ADC samples; channel k occupies bits [k*DW +: DW].
- run  in  1  level: 1 = acquire, 0 = abort to IDLE.
- deci_rate  in  TW  decimation factor; 0 is treated as 1.
- deci_mode  in  2  0 = sample, 1 = max-hold, 2 = min-hold, 3 = sample.
- trig_ch  in  clog2(CH_NUM) (min 1)  trigger source channel.
- trig_level  in  DW  trigger threshold.
- trig_hyst  in  DW  hysteresis band.
- trig_edge  in  1  0 = rising, 1 = falling.
- trig_mode  in  2  0 = auto, 1 = normal, 2 = single, 3 = normal.
- auto_timeout  in  TW  clk cycles spent in WAIT_TRIG before an auto trigger.
- force_trig  in  1  single-cycle pulse; triggers immediately in WAIT_TRIG.
- pretrig_len  in  AW  samples kept before the trigger; clamped to DEPTH-1.
- holdoff  in  TW  clk cycles after ack before re-arming.
- done  out  1  capture complete; buffer frozen.
- disp_ack  in  1  single-cycle pulse; consumer finished reading.
- busy  out  1  high in PRE, WAIT_TRIG or POST.
- trig_pos  out  AW  buffer address of the trigger sample.
- trig_auto  out  1  last capture was auto- or force-triggered.
- rd_addr  in  AW  read address.
- rd_data  out  CH_NUM*DW  registered read data.

Behaviour:
- Reset values: done=0, busy=0, trig_pos=0, trig_auto=0, rd_data=0, state=IDLE, write pointer=0, all counters=0.
- Parameter latching: deci_rate, deci_mode, trig_ch, pretrig_len and holdoff are latched on every entry to PRE. Changing them mid-capture has no effect.
- trig_level, trig_hyst and trig_edge are used live.
- Decimator:
  - Counter runs 0..R-1, with R = max(deci_rate, 1).
  - On count R-1 it emits one strobe with one sample per channel.
  - Sample mode: the input present on the strobe cycle.
  - Max/min mode: the per-channel extreme over the R inputs of the window, including the strobe cycle. The accumulator then reloads from the next input.
  - With R=1 the strobe is high every cycle.
  - Counter and accumulators clear on PRE entry.
- Buffer write: one entry (all channels) per strobe at wp; then wp <= wp+1 modulo DEPTH. Writes occur only in PRE, WAIT_TRIG and POST.
- Trigger detector:
  - Runs on strobed samples of the trig_ch channel.
  - Rising edge: arms when sample <= trig_level - trig_hyst (floored at 0); fires when armed and sample > trig_level; fire disarms.
  - Falling edge: mirror of rising — arms at >= trig_level + trig_hyst (capped at 2^DW-1), fires at < trig_level.
  - Arm state clears on PRE entry.
- State machine:
  - IDLE: run=1 -> PRE.
  - PRE: write pretrig_len samples, then -> WAIT_TRIG. pretrig_len=0 goes straight to WAIT_TRIG.
  - WAIT_TRIG:
    - Keeps writing and the timeout counter counts clk cycles.
    - Trigger sources: detector fire, force_trig, or (trig_mode=0 and timeout count == auto_timeout).
    - On trigger: trig_pos <= address of the triggering sample, i.e. the sample written that strobe. For force/auto with no strobe that cycle, trig_pos <= wp-1.
    - Then -> POST.
    - trig_auto <= 1 only if the detector did not fire in that same cycle. A detector fire simultaneous with force or timeout is a real trigger (trig_auto=0).
  - POST: write DEPTH-1-pretrig_len further samples, then -> DONE.
  - DONE: done=1. disp_ack -> HOLDOFF (done=0 the next cycle). disp_ack outside DONE is ignored.
  - HOLDOFF: count holdoff clk cycles; then -> PRE if trig_mode is 0 or 1, or -> IDLE if trig_mode=2.
- Frame layout: the buffer holds exactly pretrig_len samples before trig_pos and DEPTH-1-pretrig_len after it, addresses wrapping modulo DEPTH.
- Abort: run=0 in any state except DONE -> IDLE on the next clock; busy drops and the partial frame is discarded (done stays 0). In DONE, run=0 is ignored until ack; HOLDOFF then exits to IDLE.
- Read port: rd_data <= mem[rd_addr] with 1-cycle latency, available in all states. Contents are stable only while done=1.
- Reset mid-capture: everything returns to reset values; buffer contents are undefined.

Test Plan:
- CH_NUM=2, DEPTH=64, R=1, normal mode, rising edge, level=128, hyst=0, pretrig_len=16, ramp 0..255 on ch0 -> trigger on the first sample >128 (129). Frame has 16 samples before trig_pos and 47 after; done=1, trig_auto=0.
- Hysteresis: level=100, hyst=10, ch0 noise toggling 98/102 then a dip to 89 then 120 -> no trigger during 98/102 toggling; trigger on 120 only after 89 arms.
- Decimation R=4, max-hold, input sequence 1,7,3,2,9,4,4,4 -> stored samples 7,9. Min-hold on the same sequence -> 1,4.
- Auto mode, flat input, auto_timeout=100 -> trigger 100 cycles after WAIT_TRIG entry, trig_auto=1. Same setup with force_trig at cycle 10 -> trigger at 10, trig_auto=1.
- Single mode, holdoff=20 -> done, ack; after 20 cycles -> IDLE, busy=0. A second edge causes no capture until run toggles 0->1.
- Abort and reset: run=0 during POST -> IDLE next cycle, done never asserts. rst_n low during WAIT_TRIG -> all outputs 0 immediately.

Source files
------------

// File: rtl/scope_capture_engine.sv
// scope_capture_engine: multi-channel decimating oscilloscope capture with hysteretic edge trigger and circular pre-trigger buffer
// Ports: clk/rst_n (async active-low); ad_data = CH_NUM packed DW-bit samples; run level enables acquisition;
// deci_rate/deci_mode, trig_ch, pretrig_len, holdoff are latched when a capture starts;
// trig_level/trig_hyst/trig_edge/trig_mode/auto_timeout/force_trig are live trigger controls;
// done/disp_ack handshake a frozen frame; busy marks acquisition; trig_pos/trig_auto describe the last trigger;
// rd_addr/rd_data is a registered read port into the sample buffer.
module scope_capture_engine #(
  parameter int CH_NUM = 2,
  parameter int DW = 8,
  parameter int DEPTH = 16384,
  parameter int AW = $clog2(DEPTH),
  parameter int TW = 32,
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH_NUM*DW-1:0] ad_data,
  input  logic                 run,
  input  logic [TW-1:0]        deci_rate,
  input  logic [1:0]           deci_mode,
  input  logic [CW-1:0]        trig_ch,
  input  logic [DW-1:0]        trig_level,
  input  logic [DW-1:0]        trig_hyst,
  input  logic                 trig_edge,
  input  logic [1:0]           trig_mode,
  input  logic [TW-1:0]        auto_timeout,
  input  logic                 force_trig,
  input  logic [AW-1:0]        pretrig_len,
  input  logic [TW-1:0]        holdoff,
  output logic                 done,
  input  logic                 disp_ack,
  output logic                 busy,
  output logic [AW-1:0]        trig_pos,
  output logic                 trig_auto,
  input  logic [AW-1:0]        rd_addr,
  output logic [CH_NUM*DW-1:0] rd_data
);
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE, HOLDOFF} state_t;
  state_t state, nxt;
  logic [TW-1:0] r_deci, r_hold, cnt, tcnt, hcnt, rate;
  logic [1:0] r_mode;
  logic [CW-1:0] r_ch;
  logic [AW-1:0] r_pre, wp, scnt, tgt;
  logic armed, lock, active, strobe, fire, arm_set, trig, seg_end, enter_pre;
  logic [DW-1:0] acc [CH_NUM];
  logic [DW-1:0] val [CH_NUM];
  logic [CH_NUM*DW-1:0] wdata;
  logic [CH_NUM*DW-1:0] mem [DEPTH];
  logic [DW-1:0] ts, lo, hi;
  logic [DW:0] hsum;

  assign active = state == PRE || state == WAIT_TRIG || state == POST;
  assign rate = (r_deci == '0) ? TW'(1) : r_deci;
  assign strobe = active && cnt == rate - TW'(1);

  // first input of a window reloads the accumulator; otherwise keep the running max or min
  always_comb begin
    wdata = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      val[k] = (cnt == '0 || r_mode == 2'd0 || r_mode == 2'd3) ? ad_data[k*DW +: DW] :
               ((r_mode == 2'd1) == (ad_data[k*DW +: DW] > acc[k])) ? ad_data[k*DW +: DW] : acc[k];
      wdata[k*DW +: DW] = val[k];
    end
  end

  assign ts = val[r_ch];
  assign lo = (trig_level >= trig_hyst) ? trig_level - trig_hyst : '0;
  assign hsum = {1'b0, trig_level} + {1'b0, trig_hyst};
  assign hi = hsum[DW] ? '1 : hsum[DW-1:0];
  assign arm_set = trig_edge ? ts >= hi : ts <= lo;
  assign fire = strobe && armed && (trig_edge ? ts < trig_level : ts > trig_level);
  assign trig = run && state == WAIT_TRIG && (fire || force_trig || (trig_mode == 2'd0 && tcnt == auto_timeout));
  // PRE fills the pre-trigger part, POST the remainder of the frame after the trigger sample
  assign tgt = (state == PRE) ? r_pre : AW'(DEPTH - 1) - r_pre;
  assign seg_end = tgt == '0 || (strobe && scnt == tgt - AW'(1));
  assign enter_pre = nxt == PRE && state != PRE;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = (run && !lock) ? PRE : IDLE;
      PRE:       nxt = seg_end ? WAIT_TRIG : PRE;
      WAIT_TRIG: nxt = trig ? POST : WAIT_TRIG;
      POST:      nxt = seg_end ? DONE : POST;
      DONE:      nxt = disp_ack ? HOLDOFF : DONE;
      HOLDOFF:   nxt = (r_hold == '0 || hcnt == r_hold - TW'(1)) ? ((trig_mode == 2'd2) ? IDLE : PRE) : HOLDOFF;
      default:   nxt = IDLE;
    endcase
    if (!run && state != DONE) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      busy <= 1'b0;
      trig_pos <= '0;
      trig_auto <= 1'b0;
      wp <= '0;
      cnt <= '0;
      tcnt <= '0;
      hcnt <= '0;
      scnt <= '0;
      armed <= 1'b0;
      lock <= 1'b0;
      r_deci <= '0;
      r_mode <= '0;
      r_ch <= '0;
      r_pre <= '0;
      r_hold <= '0;
      acc <= '{default: '0};
    end else begin
      state <= nxt;
      done <= nxt == DONE;
      busy <= nxt == PRE || nxt == WAIT_TRIG || nxt == POST;
      // a single-shot return to IDLE stays parked until run is dropped
      lock <= run && (lock || (state == HOLDOFF && nxt == IDLE));
      tcnt <= (state == WAIT_TRIG) ? tcnt + TW'(1) : '0;
      hcnt <= (state == HOLDOFF) ? hcnt + TW'(1) : '0;
      if (strobe) wp <= wp + AW'(1);
      if (enter_pre) begin
        r_deci <= deci_rate;
        r_mode <= deci_mode;
        r_ch <= trig_ch;
        r_pre <= pretrig_len;
        r_hold <= holdoff;
        cnt <= '0;
        scnt <= '0;
        armed <= 1'b0;
        acc <= '{default: '0};
      end else if (active) begin
        cnt <= strobe ? '0 : cnt + TW'(1);
        acc <= val;
        scnt <= (nxt != state) ? '0 : scnt + AW'(strobe);
        if (strobe) armed <= !fire && (arm_set || armed);
      end
      // without a strobe the newest stored sample is the one just behind wp
      if (trig) begin
        trig_pos <= strobe ? wp : wp - AW'(1);
        trig_auto <= !fire;
      end
    end
  end

  always_ff @(posedge clk) if (strobe) mem[wp] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else rd_data <= mem[rd_addr];
  end
endmodule

// File: tb/tb_scope_capture_engine.sv
// tb_scope_capture_engine: directed scenario bench for scope_capture_engine
module tb_scope_capture_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] ad_data;
  logic run, trig_ch, trig_edge, force_trig, disp_ack, done, busy, trig_auto;
  logic [31:0] deci_rate, auto_timeout, holdoff;
  logic [1:0] deci_mode, trig_mode;
  logic [7:0] trig_level, trig_hyst;
  logic [5:0] pretrig_len, trig_pos, rd_addr;
  logic [15:0] rd_data;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scope_capture_engine #(.CH_NUM(2), .DW(8), .DEPTH(64), .TW(32)) dut (
    .clk(clk), .rst_n(rst_n), .ad_data(ad_data), .run(run), .deci_rate(deci_rate),
    .deci_mode(deci_mode), .trig_ch(trig_ch), .trig_level(trig_level), .trig_hyst(trig_hyst),
    .trig_edge(trig_edge), .trig_mode(trig_mode), .auto_timeout(auto_timeout),
    .force_trig(force_trig), .pretrig_len(pretrig_len), .holdoff(holdoff), .done(done),
    .disp_ack(disp_ack), .busy(busy), .trig_pos(trig_pos), .trig_auto(trig_auto),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b);
    ad_data = {8'(b), 8'(a)};
  endtask

  task automatic read_mem(input int a, output logic [15:0] d);
    rd_addr = 6'(a);
    tick();
    d = rd_data;
  endtask

  task automatic wait_done(input int max);
    for (int n = 0; n < max && !done; n++) tick();
  endtask

  task automatic pulse_force();
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
  endtask

  task automatic pulse_ack();
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    ad_data = '0;
    deci_rate = 1;
    deci_mode = 2'd0;
    trig_ch = 1'b0;
    trig_level = 8'd128;
    trig_hyst = 8'd0;
    trig_edge = 1'b0;
    trig_mode = 2'd1;
    auto_timeout = 0;
    force_trig = 1'b0;
    disp_ack = 1'b0;
    pretrig_len = 6'd16;
    holdoff = 0;
    rd_addr = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (trig_pos !== 6'd0) begin failures++; $display("FAIL reset_trig_pos got=%0d exp=0", trig_pos); end
    checks++; if (trig_auto !== 1'b0) begin failures++; $display("FAIL reset_trig_auto got=%0b exp=0", trig_auto); end
    checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    int v;
    logic [15:0] d;
    do_reset();
    v = 0;
    drive(0, 255);
    run = 1'b1;
    tick();
    for (int n = 0; n < 400; n++) begin
      tick();
      if (done) break;
      v++;
      drive(v, 255 - v);
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ramp_done got=%0b exp=1", done); end
    checks++; if (v !== 176) begin failures++; $display("FAIL ramp_last_sample got=%0d exp=176", v); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ramp_busy got=%0b exp=0", busy); end
    checks++; if (trig_pos !== 6'd1) begin failures++; $display("FAIL ramp_trig_pos got=%0d exp=1", trig_pos); end
    checks++; if (trig_auto !== 1'b0) begin failures++; $display("FAIL ramp_trig_auto got=%0b exp=0", trig_auto); end
    for (int k = -16; k < 48; k++) begin
      read_mem(1 + k, d);
      checks++;
      if (d !== {8'(126 - k), 8'(129 + k)}) begin
        failures++;
        $display("FAIL ramp_frame[%0d] got=%0h exp=%0h", k, d, {8'(126 - k), 8'(129 + k)});
      end
    end
  endtask

  task automatic test_hysteresis();
    int i;
    int f;
    logic [15:0] d;
    do_reset();
    trig_level = 8'd100;
    trig_hyst = 8'd10;
    pretrig_len = 6'd4;
    i = 0;
    drive(98, 0);
    run = 1'b1;
    tick();
    for (int n = 0; n < 300; n++) begin
      tick();
      if (done) break;
      i++;
      f = (i < 4) ? 98 : (i < 24) ? ((i % 2 == 1) ? 102 : 98) : (i == 24) ? 89 : 120;
      drive(f, 0);
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL hyst_done got=%0b exp=1", done); end
    checks++; if (i !== 84) begin failures++; $display("FAIL hyst_last_index got=%0d exp=84", i); end
    checks++; if (trig_pos !== 6'd25) begin failures++; $display("FAIL hyst_trig_pos got=%0d exp=25", trig_pos); end
    checks++; if (trig_auto !== 1'b0) begin failures++; $display("FAIL hyst_trig_auto got=%0b exp=0", trig_auto); end
    read_mem(25, d);
    checks++; if (d[7:0] !== 8'd120) begin failures++; $display("FAIL hyst_trig_sample got=%0d exp=120", d[7:0]); end
    read_mem(24, d);
    checks++; if (d[7:0] !== 8'd89) begin failures++; $display("FAIL hyst_arm_sample got=%0d exp=89", d[7:0]); end
    read_mem(23, d);
    checks++; if (d[7:0] !== 8'd102) begin failures++; $display("FAIL hyst_noise_sample got=%0d exp=102", d[7:0]); end
  endtask

  task automatic test_decimation(input int mode, input int e0, input int e1, input int f0, input int f1);
    int s[8] = '{1, 7, 3, 2, 9, 4, 4, 4};
    logic [15:0] d;
    do_reset();
    deci_rate = 4;
    deci_mode = 2'(mode);
    run = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(s[i], 20 - s[i]);
      tick();
      if (i == 0) begin
        deci_mode = 2'(3 - mode);
        deci_rate = 1;
      end
    end
    drive(5, 5);
    repeat (4) tick();
    read_mem(0, d);
    checks++; if (d !== {8'(f0), 8'(e0)}) begin failures++; $display("FAIL deci%0d_word0 got=%0h exp=%0h", mode, d, {8'(f0), 8'(e0)}); end
    read_mem(1, d);
    checks++; if (d !== {8'(f1), 8'(e1)}) begin failures++; $display("FAIL deci%0d_word1 got=%0h exp=%0h", mode, d, {8'(f1), 8'(e1)}); end
    read_mem(2, d);
    checks++; if (d !== 16'h0505) begin failures++; $display("FAIL deci%0d_word2 got=%0h exp=0505", mode, d); end
  endtask

  task automatic test_auto();
    do_reset();
    trig_mode = 2'd0;
    auto_timeout = 100;
    pretrig_len = 6'd4;
    drive(50, 60);
    run = 1'b1;
    wait_done(400);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL auto_done got=%0b exp=1", done); end
    checks++; if (trig_pos !== 6'd40) begin failures++; $display("FAIL auto_trig_pos got=%0d exp=40", trig_pos); end
    checks++; if (trig_auto !== 1'b1) begin failures++; $display("FAIL auto_trig_auto got=%0b exp=1", trig_auto); end
  endtask

  task automatic test_force();
    do_reset();
    trig_mode = 2'd0;
    auto_timeout = 100;
    pretrig_len = 6'd4;
    drive(50, 60);
    run = 1'b1;
    tick();
    repeat (14) tick();
    pulse_force();
    wait_done(200);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL force_done got=%0b exp=1", done); end
    checks++; if (trig_pos !== 6'd14) begin failures++; $display("FAIL force_trig_pos got=%0d exp=14", trig_pos); end
    checks++; if (trig_auto !== 1'b1) begin failures++; $display("FAIL force_trig_auto got=%0b exp=1", trig_auto); end
  endtask

  task automatic test_force_nostrobe();
    do_reset();
    deci_rate = 2;
    pretrig_len = 6'd2;
    drive(50, 60);
    run = 1'b1;
    tick();
    repeat (6) tick();
    pulse_force();
    wait_done(400);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL nostrobe_done got=%0b exp=1", done); end
    checks++; if (trig_pos !== 6'd2) begin failures++; $display("FAIL nostrobe_trig_pos got=%0d exp=2", trig_pos); end
    checks++; if (trig_auto !== 1'b1) begin failures++; $display("FAIL nostrobe_trig_auto got=%0b exp=1", trig_auto); end
  endtask

  task automatic test_holdoff();
    do_reset();
    pretrig_len = 6'd0;
    holdoff = 20;
    drive(50, 60);
    run = 1'b1;
    tick();
    tick();
    pulse_ack();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL early_ack_busy got=%0b exp=1", busy); end
    pulse_force();
    wait_done(200);
    tick();
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL holdoff_done_held got=%0b exp=1", done); end
    pulse_ack();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL holdoff_done_clear got=%0b exp=0", done); end
    repeat (19) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL holdoff_busy_19 got=%0b exp=0", busy); end
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL holdoff_rearm_20 got=%0b exp=1", busy); end
  endtask

  task automatic test_single();
    logic saw;
    do_reset();
    trig_mode = 2'd2;
    holdoff = 20;
    pretrig_len = 6'd0;
    drive(0, 0);
    run = 1'b1;
    tick();
    tick();
    tick();
    drive(200, 0);
    wait_done(200);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done got=%0b exp=1", done); end
    checks++; if (trig_pos !== 6'd2) begin failures++; $display("FAIL single_trig_pos got=%0d exp=2", trig_pos); end
    checks++; if (trig_auto !== 1'b0) begin failures++; $display("FAIL single_trig_auto got=%0b exp=0", trig_auto); end
    pulse_ack();
    repeat (20) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%0b exp=0", busy); end
    saw = 1'b0;
    drive(0, 0);
    for (int n = 0; n < 105; n++) begin
      if (n == 5) drive(200, 0);
      tick();
      saw = saw | busy | done;
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL single_no_rearm got=%0b exp=0", saw); end
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_run_toggle got=%0b exp=1", busy); end
  endtask

  task automatic test_abort();
    logic saw;
    do_reset();
    pretrig_len = 6'd0;
    drive(50, 60);
    run = 1'b1;
    tick();
    tick();
    pulse_force();
    repeat (5) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_post_busy got=%0b exp=1", busy); end
    run = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    saw = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      saw = saw | done | busy;
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%0b exp=0", saw); end
    run = 1'b1;
    tick();
    tick();
    pulse_force();
    wait_done(200);
    run = 1'b0;
    repeat (5) tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_ignores_run got=%0b exp=1", done); end
    pulse_ack();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_ack_clear got=%0b exp=0", done); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pretrig_len = 6'd0;
    drive(33, 44);
    rd_addr = 6'd3;
    run = 1'b1;
    repeat (4) tick();
    pulse_force();
    wait_done(200);
    checks++; if (trig_pos !== 6'd3) begin failures++; $display("FAIL mid_trig_pos got=%0d exp=3", trig_pos); end
    pulse_ack();
    repeat (5) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_wait_busy got=%0b exp=1", busy); end
    checks++; if (rd_data !== 16'h2c21) begin failures++; $display("FAIL mid_rd_data got=%0h exp=2c21", rd_data); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%0b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0b exp=0", busy); end
    checks++; if (trig_pos !== 6'd0) begin failures++; $display("FAIL mid_rst_trig_pos got=%0d exp=0", trig_pos); end
    checks++; if (trig_auto !== 1'b0) begin failures++; $display("FAIL mid_rst_trig_auto got=%0b exp=0", trig_auto); end
    checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL mid_rst_rd_data got=%0h exp=0", rd_data); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_hysteresis();
    test_decimation(1, 7, 9, 19, 16);
    test_decimation(2, 1, 4, 13, 11);
    test_auto();
    test_force();
    test_force_nostrobe();
    test_holdoff();
    test_single();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
